flip_flop_fifo_with_levels: RTL and testbench
=============================================

FLIP_FLOP_FIFO_WITH_LEVELS -- requirements
Module: flip_flop_fifo_with_levels

Interface
REQ-001 Parameter width, default 8: data word width in bits, >= 1.
REQ-002 Parameter depth, default 10: entry count, >= 2, any integer (not restricted to powers of two).
REQ-003 Parameter almost_full_margin, default 1: free-entry threshold for almost_full, range 0..depth-1.
REQ-004 Parameter almost_empty_margin, default 1: occupancy threshold for almost_empty, range 0..depth-1.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 push  input  1  write request; write_data is captured when accepted.
REQ-008 pop  input  1  read request; the head entry is removed when accepted.
REQ-009 write_data  input  width  data to enqueue.
REQ-010 read_data  output  width  head entry (show-ahead); undefined while empty.
REQ-011 empty  output  1  occupancy == 0.
REQ-012 full  output  1  occupancy == depth.
REQ-013 almost_empty  output  1  occupancy <= almost_empty_margin.
REQ-014 almost_full  output  1  occupancy >= depth - almost_full_margin.
REQ-015 count  output  $clog2(depth+1)  current occupancy, 0..depth.
REQ-016 overflow  output  1  sticky flag: a push was rejected.
REQ-017 underflow  output  1  sticky flag: a pop was rejected.

Function
REQ-018 Write and read pointers SHALL be $clog2(depth) bits, each with a wrap-parity bit toggled when the pointer wraps from depth-1 to 0.
REQ-019 empty SHALL equal (pointers equal AND parities equal); full SHALL equal (pointers equal AND parities differ); both are combinational from registered state.
REQ-020 A push SHALL be accepted when !full, or when full and pop is asserted in the same cycle.
REQ-021 A pop SHALL be accepted when !empty; a pop while empty is rejected, even if push is asserted in the same cycle.
REQ-022 An accepted push SHALL write write_data to the write pointer's entry and advance the write pointer at the same edge.
REQ-023 An accepted pop SHALL advance the read pointer; read_data SHALL combinationally present the entry at the read pointer.
REQ-024 Latency: a word pushed into an empty FIFO SHALL appear on read_data, with empty=0, in the cycle after the push edge.
REQ-025 count SHALL be a registered counter: +1 for push-only, -1 for pop-only, unchanged for both or neither (accepted operations only).
REQ-026 count SHALL always match the pointer-derived occupancy; full==(count==depth) and empty==(count==0) at all times.
REQ-027 almost_empty and almost_full SHALL be combinational from count; they may be asserted together when the margins overlap.
REQ-028 Rejected operations SHALL change no pointer, no count and no storage entry.
REQ-029 Storage SHALL be flip-flops without reset; only control state is reset.

Reset
REQ-030 While rst=1 at a rising edge: pointers, parities and count SHALL be cleared to 0, and overflow and underflow SHALL be cleared to 0, regardless of push/pop.
REQ-031 After reset: empty=1, full=0, count=0, almost_empty=1, and almost_full=(almost_full_margin>=depth, i.e. 0 for legal values).
REQ-032 Reset asserted mid-operation SHALL discard all contents; stale storage SHALL never be observable as non-empty.

Configuration
REQ-033 Macro FLIP_FLOP_FIFO_ERROR_FLAGS_EN defined: overflow SHALL be set on a rejected push, underflow SHALL be set on a rejected pop, and both SHALL hold until reset.
REQ-034 Macro undefined: overflow and underflow SHALL be tied to 0 with no flag registers; all other behaviour is identical.

Verification
REQ-035 Reset, then push 10 words 0x01..0x0A -> full=1, count=10, almost_full=1 after word 9; pop all -> read_data order 0x01..0x0A, empty=1.
REQ-036 Wrap: with depth=10, run 25 push/pop pairs interleaved at occupancy 3 -> data order preserved, count stays 3, and full/empty never assert falsely across the wrap.
REQ-037 Full with push+pop in the same cycle -> count stays 10, head advances, and the new word is read last; empty with push+pop -> count becomes 1 and, with the macro, underflow=1.
REQ-038 With the macro: push while full -> count unchanged, overflow=1 and sticky over 5 cycles; then rst=1 for 1 cycle -> overflow=0, empty=1.
REQ-039 Push 4 words, then assert rst mid-stream -> next cycle empty=1, count=0; a subsequent push 0x55 -> read_data=0x55 the following cycle.

Source files
------------

// File: rtl/flip_flop_fifo_with_levels.sv
// flip_flop_fifo_with_levels: show-ahead FIFO in flip-flops with any depth >= 2,
// pointer/parity full-empty detection, registered occupancy count and
// almost_full / almost_empty thresholds.
// Optional sticky overflow/underflow flags: define FLIP_FLOP_FIFO_ERROR_FLAGS_EN.
module flip_flop_fifo_with_levels #(
    parameter int width               = 8,
    parameter int depth               = 10,
    parameter int almost_full_margin  = 1,
    parameter int almost_empty_margin = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           write_data,
    output logic [width-1:0]           read_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = $clog2(depth + 1);
    localparam logic [ptr_w-1:0] last_slot = ptr_w'(depth - 1);
    localparam logic [cnt_w-1:0] af_level  = cnt_w'(depth - almost_full_margin);
    localparam logic [cnt_w-1:0] ae_level  = cnt_w'(almost_empty_margin);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             wr_par;
    logic             rd_par;
    logic [cnt_w-1:0] count_q;
    logic             ptr_eq;
    logic             push_ok;
    logic             pop_ok;

    // Status and handshake decode from registered state
    always_comb begin
        ptr_eq       = (wr_ptr == rd_ptr);
        empty        = ptr_eq && (wr_par == rd_par);
        full         = ptr_eq && (wr_par != rd_par);
        // A full FIFO can still take a word when a pop frees the head in the same cycle
        push_ok      = push && (!full || pop);
        pop_ok       = pop && !empty;
        count        = count_q;
        almost_empty = (count_q <= ae_level);
        almost_full  = (count_q >= af_level);
        read_data    = mem[rd_ptr];
    end

    // Storage array: data only, no reset
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= write_data;
        end
    end

    // Pointer, wrap-parity and occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_par  <= 1'b0;
            rd_par  <= 1'b0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                if (wr_ptr == last_slot) begin
                    wr_ptr <= '0;
                    wr_par <= ~wr_par;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (pop_ok) begin
                if (rd_ptr == last_slot) begin
                    rd_ptr <= '0;
                    rd_par <= ~rd_par;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FLIP_FLOP_FIFO_ERROR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && !push_ok) overflow_q  <= 1'b1;
            if (pop && !pop_ok)   underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_flip_flop_fifo_with_levels.sv
// Directed bench for flip_flop_fifo_with_levels with a queue scoreboard.
// Expected flag values follow FLIP_FLOP_FIFO_ERROR_FLAGS_EN when it is defined.
module tb_flip_flop_fifo_with_levels;

    localparam int WIDTH = 8;
    localparam int DEPTH = 10;
    localparam int AFM   = 1;
    localparam int AEM   = 1;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef FLIP_FLOP_FIFO_ERROR_FLAGS_EN
    localparam bit flags_en = 1'b1;
`else
    localparam bit flags_en = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] write_data = '0;
    logic [WIDTH-1:0] read_data;
    logic             empty, full, almost_empty, almost_full;
    logic [CW-1:0]    count;
    logic             overflow, underflow;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] sb[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    flip_flop_fifo_with_levels #(
        .width(WIDTH),
        .depth(DEPTH),
        .almost_full_margin(AFM),
        .almost_empty_margin(AEM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .write_data(write_data),
        .read_data(read_data),
        .empty(empty),
        .full(full),
        .almost_empty(almost_empty),
        .almost_full(almost_full),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int n;
        n = sb.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AEM));
        check("almost_full", 32'(almost_full), 32'(n >= DEPTH - AFM));
        check("overflow", 32'(overflow), 32'(flags_en & m_ovf));
        check("underflow", 32'(underflow), 32'(flags_en & m_unf));
        if (n != 0) check("head", 32'(read_data), 32'(sb[0]));
    endtask

    // One clock cycle with the given request; model updated after the edge.
    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
        logic acc_push, acc_pop;
        push = p;
        pop = q;
        write_data = d;
        acc_pop  = q && (sb.size() != 0);
        acc_push = p && ((sb.size() != DEPTH) || q);
        if (acc_pop) check("pop_data", 32'(read_data), 32'(sb[0]));
        @(posedge clk);
        #1;
        if (acc_pop) void'(sb.pop_front());
        if (acc_push) sb.push_back(d);
        if (p && !acc_push) m_ovf = 1'b1;
        if (q && !acc_pop) m_unf = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        check_status();
    endtask

    // Reset with requests active to show they are ignored.
    task automatic do_reset();
        rst = 1'b1;
        push = 1'b1;
        pop = 1'b1;
        write_data = 8'hCC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_status();
    endtask

    initial begin
        // Reset state
        do_reset();

        // Fill 0x01..0x0A, then drain in order
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

        // Full with simultaneous push+pop: head advances, new word goes last
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

        // Empty with push+pop: pop rejected, push accepted
        step(1'b1, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        do_reset();

        // Overflow while full, sticky across idle cycles, cleared by reset
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
        do_reset();

        // Wrap: hold occupancy at 3 through 25 push/pop pairs
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 8'(8'h70 + i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

        // Reset mid-stream discards contents; next word visible one cycle later
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h90 + i));
        do_reset();
        step(1'b1, 1'b0, 8'h55);
        step(1'b0, 1'b1, 8'h00);

        // Random mix
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
